// File: rtl/sdio_link_pkg.sv
// Shared definitions for the sdio_halfduplex_link transceiver.
//
// Contents:
//   link_state_e - link FSM state encoding
//   FRAME_BITS   - bit periods per frame on the wire:
//                  start + 8 data + [parity] + stop
//   clog2()      - counter width helper (minimum result is 1)
//
// Optional feature macro: SDIO_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit. It also adds the two parity states.

package sdio_link_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StTxStart,
        StTxData,
`ifdef SDIO_PARITY_EN
        StTxParity,
        StRxParity,
`endif
        StTxStop,
        StGuard,
        StRxStart,
        StRxData,
        StRxStop,
        StRxWait
    } link_state_e;

`ifdef SDIO_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    // Smallest width w >= 1 such that 2**w >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sdio_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//
// Parameters:
//   RESET_VAL - value both stages take while rst_i is high
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous, active-high reset
//   d_i      - asynchronous input
//   q_o      - synchronized output (second stage)
//   q_next_o - first-stage value: what q_o will show after the next edge.
//              It lets the parent register flags that must line up with q_o.

module sdio_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic q_next_o
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o      = sync_q;
    assign q_next_o = meta_q;

endmodule

// File: rtl/sdio_halfduplex_link.sv
// Bit-serial half-duplex transceiver on one shared, pulled-up pad.
//
// Bytes are framed UART-style on the wire, LSB first: start (0), 8 data bits,
// optional even parity, stop (1). Each bit lasts CLKS_PER_BIT cycles. After a
// transmitted stop bit the pad is released for GUARD_CYCLES before the link
// may transmit or receive again. In IDLE, a low synchronized line starts
// reception. Reception wins over a pending tx_valid.
//
// Optional feature macro: SDIO_PARITY_EN (11-bit frames with an even-parity
// bit in both directions).
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per bit period (>= 2)
//   GUARD_CYCLES - cycles the pad stays released after a TX stop bit
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   io        - shared pad; driven only while transmitting, else high-Z
//   tx_data   - byte to send; accepted when tx_valid && tx_ready
//   tx_ready  - registered; high only in IDLE with the line high
//   rx_data   - last byte received with a good frame
//   rx_valid  - one-cycle pulse when rx_data updates
//   rx_err    - one-cycle pulse on a framing or parity error
//   busy      - high in any state other than IDLE

module sdio_halfduplex_link
    import sdio_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned GUARD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        io,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    localparam int unsigned CntW   = clog2(CLKS_PER_BIT);
    localparam int unsigned GuardW = clog2(GUARD_CYCLES);

    localparam logic [CntW-1:0]   CntLast   = CntW'(CLKS_PER_BIT - 1);
    // The start bit is checked CLKS_PER_BIT/2 cycles after the start is detected.
    localparam logic [CntW-1:0]   CntHalf   = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYCLES - 1);

    link_state_e           state_d, state_q;
    logic [CntW-1:0]       cnt_d, cnt_q;
    logic [GuardW-1:0]     guard_d, guard_q;
    logic [2:0]            bit_idx_d, bit_idx_q;
    // Whole outgoing frame. Bit 0 is the level on the pad.
    logic [FRAME_BITS-1:0] tx_frame_d, tx_frame_q;
    logic [7:0]            rx_shift_d, rx_shift_q;
    logic [7:0]            rx_data_d, rx_data_q;
    logic                  rx_valid_d, rx_valid_q;
    logic                  rx_err_d, rx_err_q;
    logic                  tx_ready_d, tx_ready_q;
    logic                  busy_d, busy_q;
    logic                  oe_d, oe_q;
`ifdef SDIO_PARITY_EN
    logic                  rx_par_d, rx_par_q;
`endif

    logic io_s;
    logic io_s_next;
    logic bit_done;
    logic rx_frame_ok;

    sdio_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i    (clk),
        .rst_i    (rst),
        .d_i      (io),
        .q_o      (io_s),
        .q_next_o (io_s_next)
    );

    assign bit_done = (cnt_q == CntLast);

`ifdef SDIO_PARITY_EN
    // Even parity: data bits XOR parity bit must be 0. The stop bit must be high.
    assign rx_frame_ok = io_s && ((^rx_shift_q) == rx_par_q);
`else
    assign rx_frame_ok = io_s;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        guard_d    = guard_q;
        bit_idx_d  = bit_idx_q;
        tx_frame_d = tx_frame_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        oe_d       = oe_q;
`ifdef SDIO_PARITY_EN
        rx_par_d   = rx_par_q;
`endif

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!io_s) begin
                    state_d = StRxStart;
                end else if (tx_valid && tx_ready_q) begin
                    state_d = StTxStart;
                    oe_d    = 1'b1;
`ifdef SDIO_PARITY_EN
                    tx_frame_d = {1'b1, ^tx_data, tx_data, 1'b0};
`else
                    tx_frame_d = {1'b1, tx_data, 1'b0};
`endif
                end
            end

            StTxStart: begin
                cnt_d = cnt_q + CntW'(1);
                if (bit_done) begin
                    cnt_d      = '0;
                    tx_frame_d = {1'b1, tx_frame_q[FRAME_BITS-1:1]};
                    state_d    = StTxData;
                end
            end

            StTxData: begin
                cnt_d = cnt_q + CntW'(1);
                if (bit_done) begin
                    cnt_d      = '0;
                    tx_frame_d = {1'b1, tx_frame_q[FRAME_BITS-1:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SDIO_PARITY_EN
                        state_d = StTxParity;
`else
                        state_d = StTxStop;
`endif
                    end
                end
            end

`ifdef SDIO_PARITY_EN
            StTxParity: begin
                cnt_d = cnt_q + CntW'(1);
                if (bit_done) begin
                    cnt_d      = '0;
                    tx_frame_d = {1'b1, tx_frame_q[FRAME_BITS-1:1]};
                    state_d    = StTxStop;
                end
            end
`endif

            StTxStop: begin
                cnt_d = cnt_q + CntW'(1);
                if (bit_done) begin
                    cnt_d   = '0;
                    guard_d = '0;
                    oe_d    = 1'b0;
                    state_d = StGuard;
                end
            end

            StGuard: begin
                guard_d = guard_q + GuardW'(1);
                if (guard_q == GuardLast) begin
                    state_d = StIdle;
                end
            end

            StRxStart: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    // A line that is high again at mid-start was a glitch.
                    state_d = io_s ? StIdle : StRxData;
                end
            end

            StRxData: begin
                cnt_d = cnt_q + CntW'(1);
                if (bit_done) begin
                    cnt_d      = '0;
                    rx_shift_d = {io_s, rx_shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SDIO_PARITY_EN
                        state_d = StRxParity;
`else
                        state_d = StRxStop;
`endif
                    end
                end
            end

`ifdef SDIO_PARITY_EN
            StRxParity: begin
                cnt_d = cnt_q + CntW'(1);
                if (bit_done) begin
                    cnt_d    = '0;
                    rx_par_d = io_s;
                    state_d  = StRxStop;
                end
            end
`endif

            StRxStop: begin
                cnt_d = cnt_q + CntW'(1);
                if (bit_done) begin
                    cnt_d = '0;
                    if (rx_frame_ok) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                    state_d = StRxWait;
                end
            end

            // Wait here while the line stays low (break), so a held-low line
            // is not read as a new start bit.
            StRxWait: begin
                if (io_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                oe_d    = 1'b0;
            end
        endcase

        // io_s_next is the value io_s takes after this edge. This keeps
        // tx_ready_q equal to (IDLE && io_s) in every cycle.
        tx_ready_d = (state_d == StIdle) && io_s_next;
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            guard_q    <= '0;
            bit_idx_q  <= '0;
            tx_frame_q <= '1;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
`ifdef SDIO_PARITY_EN
            rx_par_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            guard_q    <= guard_d;
            bit_idx_q  <= bit_idx_d;
            tx_frame_q <= tx_frame_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
`ifdef SDIO_PARITY_EN
            rx_par_q   <= rx_par_d;
`endif
        end
    end

    assign io       = oe_q ? tx_frame_q[0] : 1'bz;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign busy     = busy_q;

endmodule

// File: doc/sdio_halfduplex_link.md
Name: sdio_halfduplex_link

Overview:
- Bit-serial half-duplex transceiver that owns a single bidirectional pad and drives it through the inferred tristate (output-enable) pad cell.
- Converts a byte stream to UART-style frames on the shared wire, and frames received on the wire back to bytes.
- Sits between user logic (counters, LED drivers) and the pad.
- Line idles released; an external/bench pull-up holds it high.

Parameters:
CLKS_PER_BIT, 4, clk cycles per bit period; must be ≥ 2.
GUARD_CYCLES, 8, cycles the line stays released after a TX stop bit before TX or RX may start.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
io  inout  1  shared pad; driven 0/1 when output enable is set, else 1'bz
tx_data  input  8  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block accepts tx_data this cycle
rx_data  output  8  last received byte
rx_valid  output  1  one-cycle pulse, rx_data updated
rx_err  output  1  one-cycle pulse, framing error (bad stop, or parity when enabled)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; io released (oe=0); rx_data=0.
  - tx_ready, rx_valid, rx_err and busy all go to 0.
  - Reset mid-frame aborts immediately; no partial byte is reported.
- Input path: io passes through a 2-flop synchronizer (reset value 1) to give io_s. All RX decisions use io_s.
- tx_ready is registered:
  - It is 1 only in IDLE, when io_s==1, and when not in the cycle that leaves IDLE.
  - It is 0 during rst and becomes 1 the first cycle after reset deasserts.
- Handshake: a transfer happens on an edge where tx_valid && tx_ready. tx_data is latched into a shift register and the state goes to TX_START.
- Frame format (LSB first): start 0 for CLKS_PER_BIT cycles, 8 data bits of CLKS_PER_BIT cycles each, stop 1 for CLKS_PER_BIT cycles, driven actively.
- TX:
  - io oe=1 from the cycle after the handshake through the last stop cycle.
  - Then GUARD: oe=0 for GUARD_CYCLES, then IDLE.
  - Total busy time = 10*CLKS_PER_BIT + GUARD_CYCLES cycles.
- RX trigger: in IDLE, io_s==0 moves the state to RX_START.
  - If a start edge and tx_valid occur in the same cycle, RX wins: tx_ready is 0 and tx_valid is ignored.
  - No start detect occurs in TX states or GUARD.
- RX sampling:
  - The bit counter samples at mid-bit, CLKS_PER_BIT/2 cycles after the edge, then every CLKS_PER_BIT cycles.
  - If the start bit is 1 at mid-sample, it is a glitch: return to IDLE with no pulse.
- RX completion, at the stop-bit mid-sample:
  - Stop==1: rx_data is updated and rx_valid pulses for 1 cycle.
  - Stop==0: rx_err pulses; rx_data is unchanged.
  - Either way the state becomes RX_WAIT, which returns to IDLE once io_s==1 (covers a break / held-low line).
- States: IDLE, TX_START, TX_DATA, TX_STOP, GUARD, RX_START, RX_DATA, RX_STOP, RX_WAIT. The bit index is 3 bits and wraps 7→0 into the stop/parity state.
- rx_valid and rx_err are never both 1 in the same cycle.

Optional Feature:
- Macro SDIO_PARITY_EN.
- When defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted between data and stop in both directions; frame length is 11 bit periods.
  - On RX, a parity mismatch with a good stop gives rx_err and no rx_valid.
- When undefined: 10-bit frames; no parity logic is synthesized.

Decomposition:
- Package sdio_link_pkg holds:
  - the state enum;
  - localparam FRAME_BITS (10, or 11 with SDIO_PARITY_EN);
  - the bit-counter width function clog2(CLKS_PER_BIT).
- One sub-module, sdio_sync2: the 2-flop synchronizer with a parameterizable reset value.

Test Plan:
- Reset then TX 8'hA5 (CLKS_PER_BIT=4):
  - io shows 0, then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles.
  - oe drops after 40 cycles; tx_ready returns 1 after 40+8 cycles.
- Bench drives frame 8'h3C on io → rx_valid pulses once with rx_data=8'h3C; rx_err stays 0.
- Bench drives a frame with stop=0 → rx_err pulses once, no rx_valid, rx_data keeps its previous value.
  - The line is then held low 20 cycles → no new start; IDLE only after release.
- Glitch on io low for 1 cycle in IDLE → no rx_valid/rx_err; busy returns to 0 within CLKS_PER_BIT+3 cycles.
- Start edge and tx_valid in the same cycle → RX completes first; TX byte accepted only after RX_WAIT/IDLE.
- rst asserted mid-TX at data bit 3 → io released next cycle, tx_ready=0 during rst, no spurious rx_valid.
  - With SDIO_PARITY_EN, RX of 8'h07 with parity=0 → rx_err.
